// File: rtl/sample_buffer_reader.sv
// ---------------------------------------------------------------------------
// sample_buffer_reader
//   Read side of the acquisition sample buffer. Waits for the sampler to flag
//   a complete capture, latches the sample count, reads the buffer RAM through
//   its synchronous read port and streams one framed packet (header word, then
//   the samples in address order) on a valid/ready interface. When the last
//   word has been taken it pulses buffer_release so the sampler can refill.
//
// Ports
//   sys_clk         in   system clock, rising edge
//   reset_n         in   asynchronous active-low reset (deasserted internally
//                        through a two-flop synchronizer)
//   buffer_ready    in   sampler level: buffer holds a complete capture
//   sample_count    in   number of valid samples, latched at frame start
//   rd_addr         out  buffer RAM read address
//   rd_en           out  buffer RAM read enable
//   rd_data         in   RAM read data, valid the cycle after rd_en
//   out_data        out  stream word ({2'b10,count} header / {2'b00,sample})
//   out_valid       out  out_data valid
//   out_ready       in   downstream accept
//   out_last        out  final word of the frame
//   buffer_release  out  one-cycle pulse after the final word is accepted
//   busy            out  high from frame start through the release cycle
//
// OUT_W must be at least DATA_W+2 and ADDR_W+2.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | waiting for buffer_ready while armed
// HEADER  | first read in flight, then header word presented
// STREAM  | sample words presented, RAM reads throttled by free buffer slots
// RELEASE | buffer_release pulse, busy still high
// ---------------------------------------------------------------------------
module sample_buffer_reader #(
    parameter int DATA_W = 14,
    parameter int ADDR_W = 10,
    parameter int OUT_W  = 16
) (
    input  logic              sys_clk,
    input  logic              reset_n,
    input  logic              buffer_ready,
    input  logic [ADDR_W-1:0] sample_count,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    input  logic [DATA_W-1:0] rd_data,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              buffer_release,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, HEADER, STREAM, RELEASE} state_t;

    // Reset asserts immediately, releases on a clock edge.
    logic [1:0] rst_sync;
    logic       rst_int_n;

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_int_n = rst_sync[1];

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] issue_cnt;   // next RAM address to read
    logic [ADDR_W-1:0] load_cnt;    // index of next sample to present
    logic              armed;
    logic              data_vld;    // rd_data carries a sample this cycle

    // Two-entry buffer catching RAM data the output register cannot take yet.
    logic [DATA_W-1:0] fifo_mem [2];
    logic              fifo_wr;
    logic              fifo_rd;
    logic [1:0]        fifo_cnt;

    logic              accept;
    logic              fifo_empty;
    logic              avail;
    logic              load_sample;
    logic              push;
    logic              pop;
    logic              issue;
    logic [1:0]        fifo_cnt_next;
    logic [1:0]        occupancy;
    logic [DATA_W-1:0] src_sample;
    logic [OUT_W-1:0]  header_word;
    logic [OUT_W-1:0]  sample_word;

    always_comb begin
        accept      = out_valid && out_ready;
        fifo_empty  = (fifo_cnt == 2'd0);
        avail       = !fifo_empty || data_vld;
        // Oldest sample first; an empty buffer passes RAM data straight through.
        src_sample  = fifo_empty ? rd_data : fifo_mem[fifo_rd];

        load_sample = 1'b0;
        if (state == HEADER)
            load_sample = accept && (cnt != '0) && avail;
        else if (state == STREAM)
            load_sample = (!out_valid || (accept && !out_last)) && avail;

        push          = data_vld && !(load_sample && fifo_empty);
        pop           = load_sample && !fifo_empty;
        fifo_cnt_next = fifo_cnt + {1'b0, push} - {1'b0, pop};

        // A read issued now lands two cycles later; the read already in flight
        // lands next cycle. Both must find a free slot even if the output
        // stalls throughout, so reserve room for them before issuing.
        occupancy = fifo_cnt_next + {1'b0, rd_en};
        issue     = ((state == HEADER) || (state == STREAM))
                    && (issue_cnt != cnt) && (occupancy < 2'd2);

        header_word                  = '0;
        header_word[ADDR_W-1:0]      = cnt;
        header_word[OUT_W-1 -: 2]    = 2'b10;
        sample_word                  = '0;
        sample_word[DATA_W-1:0]      = src_sample;
    end

    always_ff @(posedge sys_clk) begin
        if (push) fifo_mem[fifo_wr] <= rd_data;
    end

    always_ff @(posedge sys_clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state          <= IDLE;
            cnt            <= '0;
            issue_cnt      <= '0;
            load_cnt       <= '0;
            armed          <= 1'b1;
            data_vld       <= 1'b0;
            fifo_wr        <= 1'b0;
            fifo_rd        <= 1'b0;
            fifo_cnt       <= 2'd0;
            rd_addr        <= '0;
            rd_en          <= 1'b0;
            out_data       <= '0;
            out_valid      <= 1'b0;
            out_last       <= 1'b0;
            buffer_release <= 1'b0;
            busy           <= 1'b0;
        end else begin
            // Only a low buffer_ready re-arms start detection.
            armed    <= armed | !buffer_ready;
            data_vld <= rd_en;
            rd_en    <= issue;
            if (issue) begin
                rd_addr   <= issue_cnt;
                issue_cnt <= issue_cnt + 1'b1;
            end
            if (push) fifo_wr <= !fifo_wr;
            if (pop)  fifo_rd <= !fifo_rd;
            fifo_cnt <= fifo_cnt_next;

            if (load_sample) begin
                out_data  <= sample_word;
                out_last  <= (load_cnt == cnt - 1'b1);
                out_valid <= 1'b1;
                load_cnt  <= load_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (buffer_ready && armed) begin
                        state     <= HEADER;
                        cnt       <= sample_count;
                        armed     <= 1'b0;
                        busy      <= 1'b1;
                        load_cnt  <= '0;
                        // Sample 0 is fetched right away so it is ready
                        // by the time the header is accepted.
                        rd_en     <= (sample_count != '0);
                        rd_addr   <= '0;
                        issue_cnt <= {{(ADDR_W-1){1'b0}}, (sample_count != '0)};
                    end
                end
                HEADER: begin
                    if (!out_valid) begin
                        out_data  <= header_word;
                        out_last  <= (cnt == '0);
                        out_valid <= 1'b1;
                    end else if (accept) begin
                        if (cnt == '0) begin
                            state          <= RELEASE;
                            buffer_release <= 1'b1;
                            out_valid      <= 1'b0;
                            out_data       <= '0;
                            out_last       <= 1'b0;
                        end else begin
                            state <= STREAM;
                            if (!load_sample) begin
                                out_valid <= 1'b0;
                                out_data  <= '0;
                                out_last  <= 1'b0;
                            end
                        end
                    end
                end
                STREAM: begin
                    if (accept && out_last) begin
                        state          <= RELEASE;
                        buffer_release <= 1'b1;
                        out_valid      <= 1'b0;
                        out_data       <= '0;
                        out_last       <= 1'b0;
                    end else if (accept && !load_sample) begin
                        out_valid <= 1'b0;
                        out_data  <= '0;
                        out_last  <= 1'b0;
                    end
                end
                RELEASE: begin
                    buffer_release <= 1'b0;
                    busy           <= 1'b0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
